ppl_stall_ctrl: RTL and testbench

Pipeline stall and freeze sequencer for the 5-stage core. It sits beside the decode stage and drives the write enables of PC/regF, regD, regE, regM and regW, plus the bubble injection into regE. It arbitrates three stall sources: data-memory wait, load-use hazard and instruction-fetch wait. A watchdog abandons data-memory accesses that never complete.

---
 rtl/ppl_stall_ctrl_if.sv | 50 +++++
 rtl/ppl_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_ppl_stall_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ppl_stall_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline and its stall sequencer.
// Performance counter signals exist only when PPL_STALL_PERF_EN is defined.
interface ppl_stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic       luHazard;
   logic       iReady;
   logic       dReq;
   logic       dReady;
   logic       wValid;
   logic       pcEn;
   logic       dEn;
   logic       eBubble;
   logic       eEn;
   logic       mEn;
   logic       wEn;
   logic [1:0] state;
   logic       busErr;

`ifdef PPL_STALL_PERF_EN
   logic             perfClr;
   logic [CNT_W-1:0] cycCnt;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] retCnt;

   modport master (
      output luHazard, iReady, dReq, dReady, wValid, perfClr,
      input  pcEn, dEn, eBubble, eEn, mEn, wEn, state, busErr,
      input  cycCnt, stallCnt, retCnt
   );

   modport slave (
      input  luHazard, iReady, dReq, dReady, wValid, perfClr,
      output pcEn, dEn, eBubble, eEn, mEn, wEn, state, busErr,
      output cycCnt, stallCnt, retCnt
   );
`else
   localparam int unused_cnt_w = CNT_W;

   modport master (
      output luHazard, iReady, dReq, dReady, wValid,
      input  pcEn, dEn, eBubble, eEn, mEn, wEn, state, busErr
   );

   modport slave (
      input  luHazard, iReady, dReq, dReady, wValid,
      output pcEn, dEn, eBubble, eEn, mEn, wEn, state, busErr
   );
`endif
endinterface

// File: rtl/ppl_stall_ctrl.sv
// Stall/freeze sequencer for the 5-stage core with a data-memory watchdog.
// Define PPL_STALL_PERF_EN to add the cycle/stall/retire performance counters.
module ppl_stall_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input logic             clk,
   input logic             reset,
   ppl_stall_ctrl_if.slave bus
);
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_LU    = 2'd1;
   localparam logic [1:0] ST_IWAIT = 2'd2;
   localparam logic [1:0] ST_MWAIT = 2'd3;

   localparam logic [15:0] WD_LAST = 16'(MEM_TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        bus_err_q, bus_err_d;

   logic mem_raw, timeout, mem_wait, front_stall;
   logic pc_en, d_en, e_bubble, e_en, m_en, w_en;

   // A timed-out access counts as complete, so it no longer freezes the pipe.
   always_comb begin
      mem_raw     = bus.dReq & ~bus.dReady;
      timeout     = mem_raw & (wd_cnt_q == WD_LAST);
      mem_wait    = mem_raw & ~timeout;
      front_stall = bus.luHazard | ~bus.iReady;
   end

   always_comb begin
      if (mem_wait)
         state_d = ST_MWAIT;
      else if (bus.luHazard)
         state_d = ST_LU;
      else if (!bus.iReady)
         state_d = ST_IWAIT;
      else
         state_d = ST_RUN;

      wd_cnt_d  = ((state_q == ST_MWAIT) && mem_wait) ? wd_cnt_q + 16'd1 : 16'd0;
      bus_err_d = bus_err_q | timeout;
   end

   always_comb begin
      pc_en    = 1'b0;
      d_en     = 1'b0;
      e_bubble = 1'b0;
      e_en     = 1'b0;
      m_en     = 1'b0;
      w_en     = 1'b0;
      if (!reset && !mem_wait) begin
         e_en = 1'b1;
         m_en = 1'b1;
         w_en = 1'b1;
         // Front-end stalls hold F/D and push a bubble so the back end drains.
         if (front_stall) begin
            e_bubble = 1'b1;
         end else begin
            pc_en = 1'b1;
            d_en  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RUN;
         wd_cnt_q  <= 16'd0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_cnt_q  <= wd_cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.pcEn    = pc_en;
   assign bus.dEn     = d_en;
   assign bus.eBubble = e_bubble;
   assign bus.eEn     = e_en;
   assign bus.mEn     = m_en;
   assign bus.wEn     = w_en;
   assign bus.state   = state_q;
   assign bus.busErr  = bus_err_q | (timeout & ~reset);

`ifdef PPL_STALL_PERF_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

   always_comb begin
      if (bus.perfClr) begin
         cyc_cnt_d   = '0;
         stall_cnt_d = '0;
         ret_cnt_d   = '0;
      end else begin
         cyc_cnt_d   = cyc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~pc_en};
         ret_cnt_d   = ret_cnt_q + {{(CNT_W-1){1'b0}}, bus.wValid & w_en};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
         ret_cnt_q   <= '0;
      end else begin
         cyc_cnt_q   <= cyc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   assign bus.cycCnt   = cyc_cnt_q;
   assign bus.stallCnt = stall_cnt_q;
   assign bus.retCnt   = ret_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = &{1'b0, bus.wValid, CNT_W > 0};
`endif
endmodule

// File: tb/tb_ppl_stall_ctrl.sv
// Scoreboard bench for ppl_stall_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them. Counter checks need PPL_STALL_PERF_EN.
module tb_ppl_stall_ctrl;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 32;

   // Enable groups in the order {pcEn, dEn, eBubble, eEn, mEn, wEn}
   localparam logic [5:0] EN_OFF = 6'b000000;
   localparam logic [5:0] EN_STL = 6'b001111;
   localparam logic [5:0] EN_RUN = 6'b110111;

   typedef struct {
      string            name;
      logic [8:0]       outs;
      bit               chkPerf;
      logic [CNT_W-1:0] cyc;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] ret;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   exp_t sbQ[$];
   int   vecCnt = 0;
   int   errCnt = 0;

   bit               pendPerf = 1'b0;
   logic [CNT_W-1:0] pendCyc, pendStall, pendRet;

   always #5 clk = ~clk;

   ppl_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   ppl_stall_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Arms a counter expectation that rides along with the next vector.
   task automatic expectPerf(input int cyc, input int stall, input int ret);
      pendPerf  = 1'b1;
      pendCyc   = CNT_W'(cyc);
      pendStall = CNT_W'(stall);
      pendRet   = CNT_W'(ret);
   endtask

   // Drives one cycle of inputs just after the rising edge and queues the expected response.
   task automatic applyStimulus(input string name, input logic rst, input logic lu,
                                input logic ir, input logic dq, input logic dr,
                                input logic wv, input logic clr, input logic [5:0] en,
                                input logic [1:0] st, input logic be);
      exp_t e;
      @(posedge clk);
      #1;
      reset        = rst;
      bus.luHazard = lu;
      bus.iReady   = ir;
      bus.dReq     = dq;
      bus.dReady   = dr;
      bus.wValid   = wv;
`ifdef PPL_STALL_PERF_EN
      bus.perfClr  = clr;
`else
      if (clr) $display("[TB] note: perfClr ignored without counters");
`endif
      e.name    = name;
      e.outs    = {en, st, be};
      e.chkPerf = pendPerf;
      e.cyc     = pendCyc;
      e.stall   = pendStall;
      e.ret     = pendRet;
      pendPerf  = 1'b0;
      sbQ.push_back(e);
   endtask

   // Compares the live DUT outputs against one scoreboard entry.
   task automatic checkOutput(input exp_t e);
      logic [8:0] act;
      act = {bus.pcEn, bus.dEn, bus.eBubble, bus.eEn, bus.mEn, bus.wEn, bus.state, bus.busErr};
      vecCnt++;
      if (act !== e.outs) begin
         errCnt++;
         $display("[TB] FAIL %s: {pcEn,dEn,eBubble,eEn,mEn,wEn,state,busErr} got %b want %b",
                  e.name, act, e.outs);
      end
`ifdef PPL_STALL_PERF_EN
      if (e.chkPerf) begin
         vecCnt++;
         if ({bus.cycCnt, bus.stallCnt, bus.retCnt} !== {e.cyc, e.stall, e.ret}) begin
            errCnt++;
            $display("[TB] FAIL %s_perf: cyc/stall/ret got %0d/%0d/%0d want %0d/%0d/%0d",
                     e.name, bus.cycCnt, bus.stallCnt, bus.retCnt, e.cyc, e.stall, e.ret);
         end
      end
`endif
   endtask

   // Monitor: one response per cycle, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
      end
   end

   initial begin
      reset        = 1'b1;
      bus.luHazard = 1'b0;
      bus.iReady   = 1'b1;
      bus.dReq     = 1'b0;
      bus.dReady   = 1'b0;
      bus.wValid   = 1'b1;
`ifdef PPL_STALL_PERF_EN
      bus.perfClr  = 1'b0;
`endif
      pendCyc   = '0;
      pendStall = '0;
      pendRet   = '0;

      //             name           rst lu ir dq dr wv clr  enables  st    be
      applyStimulus("reset0",       1, 0, 1, 0, 0, 1, 0, EN_OFF, 2'd0, 1'b0);
      applyStimulus("reset1",       1, 0, 1, 0, 0, 1, 0, EN_OFF, 2'd0, 1'b0);
      for (int i = 0; i < 10; i++)
         applyStimulus("run",       0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b0);

      expectPerf(10, 0, 10);
      applyStimulus("lu",           0, 1, 1, 0, 0, 1, 0, EN_STL, 2'd0, 1'b0);
      applyStimulus("lu_after",     0, 0, 1, 0, 0, 0, 0, EN_RUN, 2'd1, 1'b0);
      expectPerf(12, 1, 11);
      applyStimulus("lu_done",      0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b0);

      applyStimulus("mw_req",       0, 0, 1, 1, 0, 1, 0, EN_OFF, 2'd0, 1'b0);
      applyStimulus("mw_wait2",     0, 0, 1, 1, 0, 1, 0, EN_OFF, 2'd3, 1'b0);
      applyStimulus("mw_wait3",     0, 0, 1, 1, 0, 1, 0, EN_OFF, 2'd3, 1'b0);
      applyStimulus("mw_ready",     0, 0, 1, 1, 1, 1, 0, EN_RUN, 2'd3, 1'b0);
      applyStimulus("mw_idle",      0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b0);
      applyStimulus("first_ready",  0, 0, 1, 1, 1, 1, 0, EN_RUN, 2'd0, 1'b0);
      applyStimulus("no_mwait",     0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b0);

      for (int i = 0; i < MEM_TIMEOUT; i++)
         applyStimulus("wd_freeze", 0, 0, 1, 1, 0, 1, 0, EN_OFF, (i == 0) ? 2'd0 : 2'd3, 1'b0);
      applyStimulus("wd_timeout",   0, 0, 1, 1, 0, 1, 0, EN_RUN, 2'd3, 1'b1);
      applyStimulus("wd_sticky0",   0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b1);
      applyStimulus("wd_sticky1",   0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b1);

      applyStimulus("all3",         0, 1, 0, 1, 0, 1, 0, EN_OFF, 2'd0, 1'b1);
      applyStimulus("all3_mw",      0, 1, 0, 1, 0, 1, 0, EN_OFF, 2'd3, 1'b1);
      applyStimulus("drop_dreq",    0, 1, 0, 0, 0, 1, 0, EN_STL, 2'd3, 1'b1);
      applyStimulus("lu_hold",      0, 1, 0, 0, 0, 1, 0, EN_STL, 2'd1, 1'b1);
      applyStimulus("drop_lu",      0, 0, 0, 0, 0, 1, 0, EN_STL, 2'd1, 1'b1);
      applyStimulus("iwait",        0, 0, 0, 0, 0, 1, 0, EN_STL, 2'd2, 1'b1);
      applyStimulus("iready",       0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd2, 1'b1);
      expectPerf(34, 14, 24);
      applyStimulus("settle",       0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b1);

      applyStimulus("perf_clr",     0, 0, 1, 0, 0, 1, 1, EN_RUN, 2'd0, 1'b1);
      expectPerf(0, 0, 0);
      applyStimulus("after_clr",    0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b1);

      expectPerf(1, 0, 1);
      applyStimulus("mw2_req",      0, 0, 1, 1, 0, 1, 0, EN_OFF, 2'd0, 1'b1);
      applyStimulus("mw2_wait",     0, 0, 1, 1, 0, 1, 0, EN_OFF, 2'd3, 1'b1);
      expectPerf(0, 0, 0);
      applyStimulus("async_reset",  1, 0, 1, 1, 0, 1, 0, EN_OFF, 2'd0, 1'b0);
      applyStimulus("post_reset",   0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b0);

      for (int i = 0; i < MEM_TIMEOUT; i++)
         applyStimulus("wd2_freeze", 0, 0, 1, 1, 0, 1, 0, EN_OFF, (i == 0) ? 2'd0 : 2'd3, 1'b0);
      applyStimulus("wd2_timeout",  0, 0, 1, 1, 0, 1, 0, EN_RUN, 2'd3, 1'b1);
      applyStimulus("wd2_sticky",   0, 0, 1, 0, 0, 1, 0, EN_RUN, 2'd0, 1'b1);

      for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(negedge clk);
      #1;
      if (sbQ.size() > 0) begin
         vecCnt++;
         errCnt++;
         $display("[TB] FAIL drain: %0d entries left in scoreboard, want 0", sbQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end
endmodule
